// File: rtl/board_input_conditioner.sv
// board_input_conditioner
// Synchronizes, debounces and edge-detects raw push-button and slide-switch
// pins. Buttons additionally get a hold-to-repeat pulse train.
//
// Handshake note: there is no valid/ready traffic here. Every *_press,
// *_release, *_change and *_repeat output is a one-cycle strobe that user
// logic samples on the next rising edge of clk; no back-pressure exists.
//
// Bit layout: buttons and switches share one conditioning pipeline.
// Buttons occupy bits [BUTTON_COUNT-1:0] and switches occupy the bits above.
module board_input_conditioner #(
  parameter int BUTTON_COUNT    = 4,
  parameter int SWITCH_COUNT    = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BUTTON_COUNT-1:0]   btn,
  input  logic [SWITCH_COUNT-1:0]   sw,
  output logic [BUTTON_COUNT-1:0]   btn_level,
  output logic [BUTTON_COUNT-1:0]   btn_press,
  output logic [BUTTON_COUNT-1:0]   btn_release,
  output logic [BUTTON_COUNT-1:0]   btn_repeat,
  output logic [SWITCH_COUNT-1:0]   sw_level,
  output logic [SWITCH_COUNT-1:0]   sw_change,
  output logic [2*BUTTON_COUNT-1:0] dbg_repeat_state
);

  localparam int N    = BUTTON_COUNT + SWITCH_COUNT;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX);

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST  = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  logic [N-1:0]         raw;
  logic [N-1:0]         s1_q;
  logic [N-1:0]         s2_q;
  logic [N-1:0]         stable_q, stable_d;
  logic [N-1:0]         edge_q, edge_d;
  logic [N-1:0][CW-1:0] cnt_q, cnt_d;

  assign raw = {sw, btn};

  // Two-flop synchronizer for every raw pin; only s2_q feeds the debouncer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // Debounce next state: a bit must disagree with its stable level for
  // DEBOUNCE_CYCLES consecutive edges before the new level is accepted.
  always_comb begin
    stable_d = stable_q;
    edge_d   = '0;
    cnt_d    = '0;
    for (int i = 0; i < N; i++) begin
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          stable_d[i] = s2_q[i];
          edge_d[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Debounce state: stable level, run counter and the one-cycle edge strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_q <= '0;
      edge_q   <= '0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      edge_q   <= edge_d;
      cnt_q    <= cnt_d;
    end
  end

  // Level and edge strobe are registered together, so they move in the same cycle.
  assign btn_level   = stable_q[BUTTON_COUNT-1:0];
  assign btn_press   = edge_q[BUTTON_COUNT-1:0] &  stable_q[BUTTON_COUNT-1:0];
  assign btn_release = edge_q[BUTTON_COUNT-1:0] & ~stable_q[BUTTON_COUNT-1:0];
  assign sw_level    = stable_q[N-1:BUTTON_COUNT];
  assign sw_change   = edge_q[N-1:BUTTON_COUNT];

  for (genvar b = 0; b < BUTTON_COUNT; b++) begin : g_rpt
    rpt_state_e    state_q, state_d;
    logic [RW-1:0] hold_q, hold_d;
    logic          pulse;

    // Repeat FSM state register and hold counter.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= RPT_IDLE;
        hold_q  <= '0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
      end
    end

    // Repeat FSM next state; an accepted release always wins over a
    // matching count, so no repeat strobe appears in the release cycle.
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      pulse   = 1'b0;
      unique case (state_q)
        RPT_IDLE: begin
          hold_d = '0;
          if (btn_press[b]) begin
            state_d = RPT_DELAY;
          end
        end
        RPT_DELAY: begin
          if (btn_release[b]) begin
            state_d = RPT_IDLE;
            hold_d  = '0;
          end else if (hold_q == RD_LAST) begin
            pulse   = 1'b1;
            state_d = RPT_REPEAT;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + RW'(1);
          end
        end
        RPT_REPEAT: begin
          if (btn_release[b]) begin
            state_d = RPT_IDLE;
            hold_d  = '0;
          end else if (hold_q == RP_LAST) begin
            pulse  = 1'b1;
            hold_d = '0;
          end else begin
            hold_d = hold_q + RW'(1);
          end
        end
        default: begin
          state_d = RPT_IDLE;
          hold_d  = '0;
        end
      endcase
    end

    assign btn_repeat[b]              = pulse;
    assign dbg_repeat_state[2*b +: 2] = state_q;
  end

endmodule
